// File: rtl/square_fill_if.sv
// ============================================================================
// Module      : square_fill_if
// Description : Command and pixel-write bundle for square_fill_ctrl.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface square_fill_if #(
    parameter int A  = 10,
    parameter int S  = 24,
    parameter int XW = 5,
    parameter int YW = 4
);
    logic            cmd_valid;
    logic            cmd_ready;
    logic            cmd_op;
    logic [XW-1:0]   cmd_x;
    logic [YW-1:0]   cmd_y;
    logic [XW:0]     cmd_size;
    logic [S-1:0]    cmd_color;
    logic [A-1:0]    mem_address;
    logic [S-1:0]    mem_data;
    logic            mem_wren;
    logic            busy;
    logic            done;

    modport master (
        output cmd_valid, cmd_op, cmd_x, cmd_y, cmd_size, cmd_color,
        input  cmd_ready, mem_address, mem_data, mem_wren, busy, done
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_x, cmd_y, cmd_size, cmd_color,
        output cmd_ready, mem_address, mem_data, mem_wren, busy, done
    );
endinterface

`default_nettype wire

// File: rtl/square_fill_ctrl.sv
// ============================================================================
// Module      : square_fill_ctrl
// Description : Writes a clipped filled square, or clears the whole grid, into
//               a pixel memory at one registered write per clock.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module square_fill_ctrl #(
    parameter int A  = 10,
    parameter int S  = 24,
    parameter int XW = 5,
    parameter int YW = 4
) (
    input  wire logic     clk,
    input  wire logic     rst_n,
    square_fill_if.slave  bus
);

    localparam int W  = 1 << XW;
    localparam int H  = 1 << YW;
    // Wide enough for x+size-1 / y+size-1 without wrapping.
    localparam int CW = ((XW > YW) ? XW : YW) + 2;

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_FILL  = 2'd1;
    localparam logic [1:0] c_CLEAR = 2'd2;
    localparam logic [1:0] c_DONE  = 2'd3;

    logic [1:0]    r_state;
    logic [1:0]    w_state_nxt;

    logic [XW-1:0] r_col;
    logic [YW-1:0] r_row;
    logic [XW-1:0] r_x0;
    logic [XW-1:0] r_xlast;
    logic [YW-1:0] r_ylast;
    logic [S-1:0]  r_color;

    logic [A-1:0]  r_mem_address;
    logic [S-1:0]  r_mem_data;
    logic          r_mem_wren;

    logic          w_accept;
    logic          w_last;
    logic [CW-1:0] w_xsum;
    logic [CW-1:0] w_ysum;
    logic [XW-1:0] w_xclip;
    logic [YW-1:0] w_yclip;

    logic          w_wr_en;
    logic [XW-1:0] w_nxt_col;
    logic [YW-1:0] w_nxt_row;
    logic [S-1:0]  w_nxt_data;

    assign w_accept = bus.cmd_valid && (r_state == c_IDLE);
    assign w_last   = (r_col == r_xlast) && (r_row == r_ylast);

    assign w_xsum  = CW'(bus.cmd_x) + CW'(bus.cmd_size) - CW'(1);
    assign w_ysum  = CW'(bus.cmd_y) + CW'(bus.cmd_size) - CW'(1);
    assign w_xclip = (w_xsum > CW'(W - 1)) ? XW'(W - 1) : w_xsum[XW-1:0];
    assign w_yclip = (w_ysum > CW'(H - 1)) ? YW'(H - 1) : w_ysum[YW-1:0];

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_accept) begin
                    if (bus.cmd_op)
                        w_state_nxt = c_CLEAR;
                    else if (bus.cmd_size == '0)
                        w_state_nxt = c_DONE;
                    else
                        w_state_nxt = c_FILL;
                end
            end
            c_FILL, c_CLEAR: begin
                if (w_last)
                    w_state_nxt = c_DONE;
            end
            c_DONE:  w_state_nxt = c_IDLE;
            default: w_state_nxt = c_IDLE;
        endcase
    end

    // Output logic: the write to be registered on the coming edge
    always_comb begin
        w_wr_en    = 1'b0;
        w_nxt_col  = r_col;
        w_nxt_row  = r_row;
        w_nxt_data = r_color;
        case (r_state)
            c_IDLE: begin
                if (w_accept && (bus.cmd_op || (bus.cmd_size != '0))) begin
                    w_wr_en    = 1'b1;
                    w_nxt_col  = bus.cmd_op ? '0 : bus.cmd_x;
                    w_nxt_row  = bus.cmd_op ? '0 : bus.cmd_y;
                    w_nxt_data = bus.cmd_color;
                end
            end
            c_FILL, c_CLEAR: begin
                if (!w_last) begin
                    w_wr_en = 1'b1;
                    if (r_col == r_xlast) begin
                        w_nxt_col = r_x0;
                        w_nxt_row = r_row + YW'(1);
                    end else begin
                        w_nxt_col = r_col + XW'(1);
                    end
                end
            end
            default: ;
        endcase
    end

    // Command latch, scan position and registered memory port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_col         <= '0;
            r_row         <= '0;
            r_x0          <= '0;
            r_xlast       <= '0;
            r_ylast       <= '0;
            r_color       <= '0;
            r_mem_address <= '0;
            r_mem_data    <= '0;
            r_mem_wren    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_x0    <= bus.cmd_op ? '0            : bus.cmd_x;
                r_xlast <= bus.cmd_op ? XW'(W - 1)    : w_xclip;
                r_ylast <= bus.cmd_op ? YW'(H - 1)    : w_yclip;
                r_color <= bus.cmd_color;
            end
            r_mem_wren <= w_wr_en;
            if (w_wr_en) begin
                r_col         <= w_nxt_col;
                r_row         <= w_nxt_row;
                r_mem_address <= A'({w_nxt_row, w_nxt_col});
                r_mem_data    <= w_nxt_data;
            end
        end
    end

    assign bus.cmd_ready   = (r_state == c_IDLE);
    assign bus.busy        = (r_state != c_IDLE);
    assign bus.done        = (r_state == c_DONE);
    assign bus.mem_address = r_mem_address;
    assign bus.mem_data    = r_mem_data;
    assign bus.mem_wren    = r_mem_wren;

endmodule

`default_nettype wire

// File: tb/tb_square_fill_ctrl.sv
// ============================================================================
// Module      : tb_square_fill_ctrl
// Description : Directed self-checking bench for square_fill_ctrl.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_square_fill_ctrl;

    logic clk;
    logic rst_n;

    square_fill_if #(.A(10), .S(24), .XW(5), .YW(4)) bus ();

    square_fill_ctrl #(.A(10), .S(24), .XW(5), .YW(4)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [9:0] addr_q[$];
    int         cyc_q[$];
    int         bad_data;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Caller aligns to a negedge; returns #1 after the accepting edge (cycle 1).
    task automatic send(input logic op, input logic [4:0] x, input logic [3:0] y,
                        input logic [5:0] size, input logic [23:0] color, input bit hold);
        bus.cmd_op    = op;
        bus.cmd_x     = x;
        bus.cmd_y     = y;
        bus.cmd_size  = size;
        bus.cmd_color = color;
        bus.cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) bus.cmd_valid = 1'b0;
    endtask

    task automatic collect(input int budget, input logic [23:0] exp_data, output int done_cyc);
        bad_data = 0;
        done_cyc = -1;
        addr_q.delete();
        cyc_q.delete();
        for (int cyc = 1; cyc <= budget; cyc++) begin
            if (bus.mem_wren) begin
                addr_q.push_back(bus.mem_address);
                cyc_q.push_back(cyc);
                if (bus.mem_data !== exp_data) bad_data++;
            end
            if (bus.done) begin
                done_cyc = cyc;
                break;
            end
            @(posedge clk);
            #1;
        end
        check("done_seen", 64'(done_cyc >= 0), 64'd1);
    endtask

    int dcyc;
    int bad;
    bit found;

    initial begin
        rst_n         = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 1'b0;
        bus.cmd_x     = '0;
        bus.cmd_y     = '0;
        bus.cmd_size  = '0;
        bus.cmd_color = '0;

        // Reset values
        #12;
        check("rst_wren",  64'(bus.mem_wren),    64'd0);
        check("rst_busy",  64'(bus.busy),        64'd0);
        check("rst_done",  64'(bus.done),        64'd0);
        check("rst_ready", 64'(bus.cmd_ready),   64'd1);
        check("rst_addr",  64'(bus.mem_address), 64'd0);
        check("rst_data",  64'(bus.mem_data),    64'd0);

        // Basic fill, accepted on the first edge after release
        @(negedge clk);
        rst_n = 1'b1;
        send(1'b0, 5'd2, 4'd3, 6'd2, 24'hFF0000, 1'b0);
        bus.cmd_x     = 5'd7;
        bus.cmd_color = 24'h000000;
        collect(20, 24'hFF0000, dcyc);
        check("fill_cnt",  64'(addr_q.size()), 64'd4);
        if (addr_q.size() == 4) begin
            check("fill_a0", 64'(addr_q[0]), 64'd98);
            check("fill_a1", 64'(addr_q[1]), 64'd99);
            check("fill_a2", 64'(addr_q[2]), 64'd130);
            check("fill_a3", 64'(addr_q[3]), 64'd131);
            check("fill_c0", 64'(cyc_q[0]), 64'd1);
            check("fill_c3", 64'(cyc_q[3]), 64'd4);
        end
        check("fill_data", 64'(bad_data), 64'd0);
        check("fill_done", 64'(dcyc),     64'd5);
        check("fill_busy_done", 64'(bus.busy), 64'd1);
        @(posedge clk); #1;
        check("fill_ready", 64'(bus.cmd_ready), 64'd1);
        check("fill_busy",  64'(bus.busy),      64'd0);
        check("fill_hold_addr", 64'(bus.mem_address), 64'd131);

        // Clipping at the bottom-right corner
        @(negedge clk);
        send(1'b0, 5'd30, 4'd15, 6'd4, 24'h00FF00, 1'b0);
        collect(20, 24'h00FF00, dcyc);
        check("clip_cnt", 64'(addr_q.size()), 64'd2);
        if (addr_q.size() == 2) begin
            check("clip_a0", 64'(addr_q[0]), 64'd510);
            check("clip_a1", 64'(addr_q[1]), 64'd511);
        end
        check("clip_data", 64'(bad_data), 64'd0);
        check("clip_done", 64'(dcyc),     64'd3);

        // Zero-size fill: no writes, outputs hold
        @(posedge clk); #1;
        @(negedge clk);
        send(1'b0, 5'd5, 4'd5, 6'd0, 24'h0000FF, 1'b0);
        collect(20, 24'h0000FF, dcyc);
        check("zero_cnt",  64'(addr_q.size()), 64'd0);
        check("zero_done", 64'(dcyc),          64'd1);
        check("zero_hold_addr", 64'(bus.mem_address), 64'd511);
        check("zero_hold_data", 64'(bus.mem_data),    64'h00FF00);

        // Clear with cmd_valid held and inputs changed mid-command
        @(posedge clk); #1;
        @(negedge clk);
        send(1'b1, 5'd9, 4'd9, 6'd3, 24'h000000, 1'b1);
        bus.cmd_op    = 1'b0;
        bus.cmd_color = 24'h123456;
        collect(600, 24'h000000, dcyc);
        bus.cmd_valid = 1'b0;
        check("clr_cnt", 64'(addr_q.size()), 64'd512);
        bad = 0;
        foreach (addr_q[i]) begin
            if (addr_q[i] != 10'(i) || cyc_q[i] != i + 1) bad++;
        end
        check("clr_order", 64'(bad),      64'd0);
        check("clr_data",  64'(bad_data), 64'd0);
        check("clr_done",  64'(dcyc),     64'd513);
        @(posedge clk); #1;
        check("clr_ready", 64'(bus.cmd_ready), 64'd1);
        check("clr_wren",  64'(bus.mem_wren),  64'd0);

        // Asynchronous reset in the middle of a clear
        @(negedge clk);
        send(1'b1, 5'd0, 4'd0, 6'd0, 24'hABCDEF, 1'b0);
        found = 1'b0;
        for (int c = 0; c < 200; c++) begin
            if (bus.mem_wren && bus.mem_address == 10'd99) begin
                found = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        check("abort_reach99", 64'(found), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_wren",  64'(bus.mem_wren),  64'd0);
        check("abort_busy",  64'(bus.busy),      64'd0);
        check("abort_done",  64'(bus.done),      64'd0);
        check("abort_ready", 64'(bus.cmd_ready), 64'd1);
        @(posedge clk); #1;
        check("abort_done2", 64'(bus.done), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        send(1'b0, 5'd0, 4'd1, 6'd1, 24'h5A5A5A, 1'b0);
        collect(20, 24'h5A5A5A, dcyc);
        check("post_cnt", 64'(addr_q.size()), 64'd1);
        if (addr_q.size() == 1) check("post_addr", 64'(addr_q[0]), 64'd32);
        check("post_data", 64'(bad_data), 64'd0);
        check("post_done", 64'(dcyc),     64'd2);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
